// File: rtl/top.sv
// LWE-style ciphertext arithmetic accelerator behind a Wishbone slave port.
// The host fills a word-addressed scratch memory, then writes an opcode word
// naming two source vectors and a destination. The engine loads all operands
// in one cycle, computes every result in one cycle, then writes one result per
// cycle back into the scratch memory.
module top #(
    parameter int          CIPHERTEXT_MODULUS = 1024,
    parameter int          CIPHERTEXT_WIDTH   = 32,
    parameter int          DIMENSION          = 2,
    parameter int          ADDR_WIDTH         = 9,
    parameter int          DEPTH              = 256,
    parameter logic [31:0] OPCODE_ADDR        = 32'h3000_0000,
    parameter int          ENC_SCALE          = 8,
    parameter int          ENC_OFFSET         = 1006
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    localparam int L    = DIMENSION + 1;       // vector length
    localparam int NRES = 2 * L - 1;           // longest result (polynomial product)
    localparam int QB   = $clog2(CIPHERTEXT_MODULUS);
    localparam int MAW  = $clog2(DEPTH);
    localparam int CW   = $clog2(NRES + 1);

    // Opcode word field positions
    localparam int A_LSB = 2;
    localparam int B_LSB = 2 + ADDR_WIDTH;
    localparam int O_LSB = 2 + 2 * ADDR_WIDTH;

    localparam logic [1:0] OP_ENC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam logic [QB-1:0] ENC_SCALE_Q  = QB'(ENC_SCALE);
    localparam logic [QB-1:0] ENC_OFFSET_Q = QB'(ENC_OFFSET);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    // Scratch memory: a register array so the engine can read 2*L words at once
    logic [CIPHERTEXT_WIDTH-1:0] mem [DEPTH];

    state_t          state_reg, state_next;
    logic [CW-1:0]   idx_reg, idx_next;
    logic            ack_reg;
    logic [31:0]     dat_reg;
    logic            launch_cond_reg;
    logic [1:0]      op_reg;
    logic [MAW-1:0]  a_base_reg, b_base_reg, o_base_reg;

    // Operands and results only need their low QB bits: q divides 2^32, so
    // reducing the full 32-bit products mod q gives the same answer.
    logic [QB-1:0]   a_reg   [L];
    logic [QB-1:0]   b_reg   [L];
    logic [QB-1:0]   res_reg [NRES];
    logic [QB-1:0]   res_next[NRES];
    logic [QB-1:0]   mul_sum [NRES];
    logic [QB-1:0]   dot_sum;

    logic            req, host_acc, in_mem, is_op, host_we, busy;
    logic            launch_cond, launch;
    logic [MAW-1:0]  host_adr;
    logic [CW-1:0]   n_writes;
    logic            eng_we;
    logic [MAW-1:0]  eng_addr;
    logic [QB-1:0]   eng_res;
    logic [CIPHERTEXT_WIDTH-1:0] eng_wdata;

    // Byte selects are not used: every access is a full word
    logic unused_sel;
    assign unused_sel = ^wbs_sel_i;

    assign req       = wbs_stb_i & wbs_cyc_i;
    assign host_acc  = req & ~ack_reg;
    assign in_mem    = wbs_adr_i < 32'(DEPTH);
    assign is_op     = wbs_adr_i == OPCODE_ADDR;
    assign host_we   = host_acc & wbs_we_i & in_mem;
    assign host_adr  = wbs_adr_i[MAW-1:0];
    assign busy      = state_reg != IDLE;

    // Launch on the rising edge of a start-bit opcode write, only when idle
    assign launch_cond = req & wbs_we_i & is_op & wbs_dat_i[31];
    assign launch      = launch_cond & ~launch_cond_reg & (state_reg == IDLE);

    assign n_writes = (op_reg == OP_DEC) ? CW'(1) :
                      (op_reg == OP_MUL) ? CW'(NRES) : CW'(L);

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;

    // Bus handshake, read data, launch edge detect and latched opcode fields
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_reg         <= 1'b0;
            dat_reg         <= '0;
            launch_cond_reg <= 1'b0;
            op_reg          <= OP_ENC;
            a_base_reg      <= '0;
            b_base_reg      <= '0;
            o_base_reg      <= '0;
        end else begin
            ack_reg         <= req & ~ack_reg;
            launch_cond_reg <= launch_cond;
            if (host_acc && !wbs_we_i) begin
                if (in_mem)
                    dat_reg <= mem[host_adr];
                else if (is_op)
                    dat_reg <= {31'b0, busy};
                else
                    dat_reg <= '0;
            end
            if (launch) begin
                op_reg     <= wbs_dat_i[1:0];
                a_base_reg <= wbs_dat_i[A_LSB +: MAW];
                b_base_reg <= wbs_dat_i[B_LSB +: MAW];
                o_base_reg <= wbs_dat_i[O_LSB +: MAW];
            end
        end
    end

    // Engine state register
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Engine next-state logic and write strobe
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        eng_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (launch) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            LOAD: begin
                state_next = COMPUTE;
            end
            COMPUTE: begin
                state_next = WRITE;
                idx_next   = '0;
            end
            WRITE: begin
                eng_we = 1'b1;
                if (idx_reg == n_writes - CW'(1))
                    state_next = IDLE;
                else
                    idx_next = idx_reg + CW'(1);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand fetch: every A and B element is captured in LOAD, before any
    // result is written, so overlapping OUT regions stay correct.
    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_load
            // Capture one A and one B element (base + gi wraps mod DEPTH)
            always_ff @(posedge wb_clk_i) begin
                if (state_reg == LOAD) begin
                    a_reg[gi] <= mem[a_base_reg + MAW'(gi)][QB-1:0];
                    b_reg[gi] <= mem[b_base_reg + MAW'(gi)][QB-1:0];
                end
            end
        end
    endgenerate

    // Result arithmetic for all four operations, mod q by truncation
    always_comb begin
        dot_sum = '0;
        for (int k = 0; k < NRES; k++) begin
            mul_sum[k]  = '0;
            res_next[k] = '0;
        end
        for (int i = 0; i < L; i++) begin
            dot_sum = dot_sum + a_reg[i] * b_reg[i];
            for (int j = 0; j < L; j++) begin
                mul_sum[i + j] = mul_sum[i + j] + a_reg[i] * b_reg[j];
            end
        end
        case (op_reg)
            OP_ENC: begin
                for (int i = 0; i < L; i++)
                    res_next[i] = a_reg[i] * ENC_SCALE_Q + ENC_OFFSET_Q;
            end
            OP_DEC: begin
                res_next[0] = dot_sum;
            end
            OP_ADD: begin
                for (int i = 0; i < L; i++)
                    res_next[i] = a_reg[i] + b_reg[i];
            end
            default: begin
                for (int k = 0; k < NRES; k++)
                    res_next[k] = mul_sum[k];
            end
        endcase
    end

    // Result register, filled in the COMPUTE cycle
    always_ff @(posedge wb_clk_i) begin
        if (state_reg == COMPUTE) begin
            for (int k = 0; k < NRES; k++)
                res_reg[k] <= res_next[k];
        end
    end

    // Pick the result for the current write slot
    always_comb begin
        eng_res = '0;
        for (int k = 0; k < NRES; k++) begin
            if (idx_reg == CW'(k))
                eng_res = res_reg[k];
        end
    end

    assign eng_addr  = o_base_reg + MAW'(idx_reg);
    assign eng_wdata = CIPHERTEXT_WIDTH'(eng_res);

    // Memory write ports: the engine write comes last so it wins on a collision
    always_ff @(posedge wb_clk_i) begin
        if (host_we)
            mem[host_adr] <= wbs_dat_i;
        if (eng_we)
            mem[eng_addr] <= eng_wdata;
    end

endmodule

// File: tb/tb_top.sv
// Directed bench for the ciphertext accelerator: preload, run each opcode,
// then held/overlapping opcode writes, mid-run reset and out-of-range access.
module tb_top;

    localparam logic [31:0] OPA = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        rst_n    = 1'b1;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i  = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    int checks = 0;
    int errors = 0;

    top dut (
        .wb_clk_i  (wb_clk_i),
        .rst_n     (rst_n),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One bus transaction, bounded wait for ack
    task automatic wb_cycle(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, output logic [31:0] rdat);
        logic got;
        got  = 1'b0;
        rdat = '0;
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin
                got  = 1'b1;
                rdat = wbs_dat_o;
            end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        check("ack_seen", {31'b0, got}, 32'd1);
        $display("%s adr=%h dat=%0d", we ? "wr" : "rd", adr, we ? dat : rdat);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        wb_cycle(1'b1, adr, dat, dummy);
    endtask

    task automatic read_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb_cycle(1'b0, adr, 32'd0, r);
        check(tag, r, exp);
    endtask

    function automatic logic [31:0] mk_op(input logic [1:0] op, input logic [8:0] a,
                                          input logic [8:0] b, input logic [8:0] o);
        return {1'b1, 2'b00, o, b, a, op};
    endfunction

    initial begin : stim
        int acks;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        repeat (3) @(negedge wb_clk_i);
        rst_n = 1'b1;

        // Preload operands
        for (int i = 0; i < 6; i++) begin
            wb_write(32'(i), 32'(10 + i));
            wb_write(32'(100 + i), 32'(20 + i));
        end
        wb_write(32'd110, 32'd1);
        wb_write(32'd111, 32'd2);
        wb_write(32'd112, 32'd3);
        wb_write(32'd90, 32'd7);
        read_check("rd_mem3", 32'd3, 32'd13);
        read_check("rd_mem104", 32'd104, 32'd24);

        // Out-of-range write ignored, out-of-range read gives 0
        wb_write(32'd259, 32'd99);
        read_check("rd_mem3_after_oor_wr", 32'd3, 32'd13);
        read_check("rd_oor", 32'd300, 32'd0);

        // Add
        wb_write(OPA, mk_op(2'b10, 9'd0, 9'd100, 9'd50));
        read_check("busy_add", OPA, 32'd1);
        repeat (10) @(posedge wb_clk_i);
        read_check("idle_add", OPA, 32'd0);
        read_check("add0", 32'd50, 32'd30);
        read_check("add1", 32'd51, 32'd32);
        read_check("add2", 32'd52, 32'd34);

        // Decrypt
        wb_write(OPA, mk_op(2'b01, 9'd0, 9'd100, 9'd30));
        repeat (10) @(posedge wb_clk_i);
        read_check("dec0", 32'd30, 32'd695);

        // Multiply
        wb_write(OPA, mk_op(2'b11, 9'd0, 9'd100, 9'd40));
        repeat (10) @(posedge wb_clk_i);
        read_check("mul0", 32'd40, 32'd200);
        read_check("mul1", 32'd41, 32'd430);
        read_check("mul2", 32'd42, 32'd691);
        read_check("mul3", 32'd43, 32'd494);
        read_check("mul4", 32'd44, 32'd264);

        // Encrypt
        wb_write(OPA, mk_op(2'b00, 9'd0, 9'd100, 9'd70));
        repeat (10) @(posedge wb_clk_i);
        read_check("enc0", 32'd70, 32'd62);
        read_check("enc1", 32'd71, 32'd70);
        read_check("enc2", 32'd72, 32'd78);

        // Held opcode write: in-place doubling, a relaunch would double twice
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = OPA;  wbs_dat_i = mk_op(2'b10, 9'd110, 9'd110, 9'd110);
        acks = 0;
        repeat (9) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) acks++;
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        $display("wr adr=%h held 9 cycles acks=%0d", OPA, acks);
        check("held_acks", 32'(acks), 32'd5);
        repeat (10) @(posedge wb_clk_i);
        read_check("held0", 32'd110, 32'd2);
        read_check("held1", 32'd111, 32'd4);
        read_check("held2", 32'd112, 32'd6);

        // Opcode write while busy is ignored
        wb_write(OPA, mk_op(2'b10, 9'd0, 9'd100, 9'd60));
        wb_write(OPA, mk_op(2'b00, 9'd0, 9'd100, 9'd90));
        repeat (10) @(posedge wb_clk_i);
        read_check("busy_add0", 32'd60, 32'd30);
        read_check("busy_add1", 32'd61, 32'd32);
        read_check("busy_add2", 32'd62, 32'd34);
        read_check("busy_ignored", 32'd90, 32'd7);
        read_check("busy_idle", OPA, 32'd0);

        // Reset mid-multiply
        read_check("pre_rst_mem3", 32'd3, 32'd13);
        wb_write(OPA, mk_op(2'b11, 9'd0, 9'd100, 9'd150));
        @(posedge wb_clk_i); #1;
        rst_n = 1'b0;
        #2;
        check("midrst_ack", {31'b0, wbs_ack_o}, 32'd0);
        check("midrst_dat", wbs_dat_o, 32'd0);
        #2 rst_n = 1'b1;
        read_check("midrst_busy", OPA, 32'd0);
        wb_write(OPA, mk_op(2'b10, 9'd0, 9'd100, 9'd160));
        repeat (10) @(posedge wb_clk_i);
        read_check("post_rst_add0", 32'd160, 32'd30);
        read_check("post_rst_add1", 32'd161, 32'd32);
        read_check("post_rst_add2", 32'd162, 32'd34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
